// File: rtl/dm_axi_master.sv
// Single-beat AXI4-Lite master behind the L1 data cache: one outstanding
// read or write at a time, completed on a one-cycle ready pulse.
module dm_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // cache controller side
  input  logic              DM_enable,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_wdata,
  input  logic [3:0]        DM_wstrb,
  output logic              ready,
  output logic [DATA_W-1:0] DataIn,
  output logic              resp_err,
  // read address / data channels
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  // write address / data / response channels
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // performance counters
  output logic [63:0]       bus_rd_cnt,
  output logic [63:0]       bus_wr_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic              aw_done, w_done;
  logic              err_q;

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next state defaults to the current state before the case, so no
  // path through this block leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (DM_enable) state_nxt = DM_write ? S_WR : S_AR;
      S_AR:   if (ARREADY)   state_nxt = S_R;
      S_R:    if (RVALID)    state_nxt = S_DONE;
      // a channel counts as done if it finished earlier or handshakes now
      S_WR:   if ((aw_done || AWREADY) && (w_done || WREADY)) state_nxt = S_B;
      S_B:    if (BVALID)    state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register here is a plain flop (no memory arrays), so all of
  // them take the async reset and the outputs read as 0 during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err_q      <= 1'b0;
      bus_rd_cnt <= '0;
      bus_wr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (DM_enable) begin
          addr_q  <= DM_address & ALIGN_MASK;
          write_q <= DM_write;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (DM_write) begin
            wdata_q <= DM_wdata;
            wstrb_q <= DM_wstrb;
          end
        end
        S_R: if (RVALID) begin
          rdata_q <= RDATA;
          err_q   <= (RRESP != 2'b00);
        end
        S_WR: begin
          if (AWVALID && AWREADY) aw_done <= 1'b1;
          if (WVALID && WREADY)   w_done  <= 1'b1;
        end
        S_B: if (BVALID) err_q <= (BRESP != 2'b00);
        S_DONE: begin
          if (write_q) bus_wr_cnt <= bus_wr_cnt + 64'd1;
          else         bus_rd_cnt <= bus_rd_cnt + 64'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; nothing flows through from AXI inputs.
  assign ARVALID  = (state == S_AR);
  assign RREADY   = (state == S_R);
  assign AWVALID  = (state == S_WR) && !aw_done;
  assign WVALID   = (state == S_WR) && !w_done;
  assign BREADY   = (state == S_B);
  assign ready    = (state == S_DONE);
  assign resp_err = (state == S_DONE) && err_q;
  assign DataIn   = rdata_q;
  assign ARADDR   = addr_q;
  assign AWADDR   = addr_q;
  assign WDATA    = wdata_q;
  assign WSTRB    = wstrb_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: the bench plays cache controller and AXI
// slave; expected completions are queued at request time and popped on ready.
module tb_dm_axi_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk, rst;
  logic              DM_enable, DM_write;
  logic [ADDR_W-1:0] DM_address;
  logic [DATA_W-1:0] DM_wdata;
  logic [3:0]        DM_wstrb;
  logic              ready, resp_err;
  logic [DATA_W-1:0] DataIn;
  logic [ADDR_W-1:0] ARADDR, AWADDR;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [DATA_W-1:0] RDATA, WDATA;
  logic [1:0]        RRESP, BRESP;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]        WSTRB;
  logic [63:0]       bus_rd_cnt, bus_wr_cnt;

  dm_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
    .DM_wdata(DM_wdata), .DM_wstrb(DM_wstrb),
    .ready(ready), .DataIn(DataIn), .resp_err(resp_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .bus_rd_cnt(bus_rd_cnt), .bus_wr_cnt(bus_wr_cnt)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   ar_hs = 0;
  int   ready_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ARVALID && ARREADY) ar_hs++;
    if (ready) ready_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"},    ready,      0);
    check({tag, ".DataIn"},   DataIn,     0);
    check({tag, ".resp_err"}, resp_err,   0);
    check({tag, ".ARVALID"},  ARVALID,    0);
    check({tag, ".RREADY"},   RREADY,     0);
    check({tag, ".AWVALID"},  AWVALID,    0);
    check({tag, ".WVALID"},   WVALID,     0);
    check({tag, ".BREADY"},   BREADY,     0);
    check({tag, ".ARADDR"},   ARADDR,     0);
    check({tag, ".AWADDR"},   AWADDR,     0);
    check({tag, ".WDATA"},    WDATA,      0);
    check({tag, ".WSTRB"},    WSTRB,      0);
    check({tag, ".rd_cnt"},   bus_rd_cnt, 0);
    check({tag, ".wr_cnt"},   bus_wr_cnt, 0);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic push,
                       input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    DM_enable  = 1'b1;
    DM_write   = wr;
    DM_address = addr;
    DM_wdata   = wd;
    DM_wstrb   = ws;
    if (push) begin
      e.wr = wr; e.data = exp_data; e.err = exp_err;
      sb.push_back(e);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, ".ready"}, ready, 1);
    check({tag, ".sb_has_entry"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (!e.wr) check({tag, ".DataIn"}, DataIn, e.data);
      check({tag, ".resp_err"}, resp_err, e.err);
    end
  endtask

  task automatic run_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    ARREADY = 1'b1;
    issue(1'b0, addr, '0, '0, 1'b1, data, resp != 2'b00);
    tick();
    check({tag, ".ARVALID"}, ARVALID, 1);
    check({tag, ".ARADDR"},  ARADDR,  addr & 32'hFFFF_FFFC);
    tick();
    check({tag, ".ARVALID_drop"}, ARVALID, 0);
    check({tag, ".RREADY"},  RREADY,  1);
    check({tag, ".early_ready"}, ready, 0);
    RVALID = 1'b1; RDATA = data; RRESP = resp;
    tick();
    RVALID = 1'b0; RRESP = 2'b00;
    pop_check(tag);
    DM_enable = 1'b0;
    tick();
    check({tag, ".ready_width"}, ready, 0);
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [1:0] resp);
    AWREADY = 1'b1; WREADY = 1'b1;
    issue(1'b1, addr, wd, ws, 1'b1, '0, resp != 2'b00);
    tick();
    check({tag, ".AWVALID"}, AWVALID, 1);
    check({tag, ".WVALID"},  WVALID,  1);
    check({tag, ".AWADDR"},  AWADDR,  addr & 32'hFFFF_FFFC);
    check({tag, ".WDATA"},   WDATA,   wd);
    check({tag, ".WSTRB"},   WSTRB,   ws);
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    check({tag, ".BREADY"},  BREADY,  1);
    check({tag, ".valids_drop"}, {AWVALID, WVALID}, 0);
    BVALID = 1'b1; BRESP = resp;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    pop_check(tag);
    DM_enable = 1'b0;
    tick();
    check({tag, ".ready_width"}, ready, 0);
  endtask

  initial begin
    int ar0, rdy0;
    rst = 1'b0;
    DM_enable = 0; DM_write = 0; DM_address = '0; DM_wdata = '0; DM_wstrb = '0;
    ARREADY = 0; RDATA = '0; RRESP = '0; RVALID = 0;
    AWREADY = 0; WREADY = 0; BRESP = '0; BVALID = 0;
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    // zero-wait read
    run_read("t1", 32'h0000_1234, 32'hDEAD_BEEF, 2'b00);
    check("t1.rd_cnt", bus_rd_cnt, 1);
    check("t1.DataIn_held", DataIn, 32'hDEAD_BEEF);

    // write with AW accepted at N+1, W held until N+4
    AWREADY = 1'b1; WREADY = 1'b0;
    issue(1'b1, 32'h0000_2008, 32'h1122_3344, 4'b0011, 1'b1, '0, 1'b0);
    tick();
    check("t2.AWVALID", AWVALID, 1);
    check("t2.WVALID",  WVALID,  1);
    check("t2.AWADDR",  AWADDR,  32'h0000_2008);
    tick();
    AWREADY = 1'b0;
    check("t2.AWVALID_drop", AWVALID, 0);
    check("t2.WVALID_n2",    WVALID,  1);
    check("t2.BREADY_n2",    BREADY,  0);
    tick();
    check("t2.WVALID_n3", WVALID, 1);
    check("t2.WDATA_n3",  WDATA,  32'h1122_3344);
    tick();
    check("t2.WVALID_n4", WVALID, 1);
    check("t2.WDATA_n4",  WDATA,  32'h1122_3344);
    check("t2.WSTRB_n4",  WSTRB,  4'b0011);
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    check("t2.WVALID_drop", WVALID, 0);
    check("t2.BREADY_n5",   BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    pop_check("t2");
    DM_enable = 1'b0;
    tick();
    check("t2.ready_width", ready, 0);
    check("t2.wr_cnt", bus_wr_cnt, 1);

    // stalled read, misaligned request address, address changed mid-flight
    ARREADY = 1'b0;
    issue(1'b0, 32'h0000_3003, '0, '0, 1'b1, 32'hCAFE_F00D, 1'b0);
    tick();
    DM_address = 32'h9999_0000;
    for (int i = 0; i < 3; i++) begin
      check("t3.ARVALID_stall", ARVALID, 1);
      check("t3.ARADDR_stall",  ARADDR,  32'h0000_3000);
      tick();
    end
    ARREADY = 1'b1;
    check("t3.ARVALID_hs", ARVALID, 1);
    check("t3.ARADDR_hs",  ARADDR,  32'h0000_3000);
    tick();
    ARREADY = 1'b0;
    check("t3.ARVALID_drop", ARVALID, 0);
    for (int i = 0; i < 5; i++) begin
      check("t3.RREADY_wait", RREADY, 1);
      check("t3.ready_wait",  ready,  0);
      tick();
    end
    RVALID = 1'b1; RDATA = 32'hCAFE_F00D; RRESP = 2'b00;
    tick();
    RVALID = 1'b0;
    pop_check("t3");
    DM_enable = 1'b0;
    tick();
    check("t3.ready_width", ready, 0);
    check("t3.DataIn_held", DataIn, 32'hCAFE_F00D);

    // error responses
    run_read("t4r", 32'h0000_4000, 32'h0BAD_0BAD, 2'b10);
    run_write("t4w", 32'h0000_4004, 32'hA5A5_A5A5, 4'hF, 2'b11);
    check("t4.rd_cnt", bus_rd_cnt, 3);
    check("t4.wr_cnt", bus_wr_cnt, 2);

    // reset while in R with read data pending
    rdy0 = ready_seen;
    ARREADY = 1'b1;
    issue(1'b0, 32'h0000_5000, '0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("t5.RREADY_pre", RREADY, 1);
    RVALID = 1'b1; RDATA = 32'h1234_5678;
    #2 rst = 1'b0;
    #1;
    check_all_zero("t5");
    RVALID = 1'b0; DM_enable = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t5.idle_ARVALID", ARVALID, 0);
    check("t5.idle_RREADY",  RREADY,  0);
    check("t5.no_ready", ready_seen, rdy0);

    // 4-word refill with DM_enable held high
    ar0  = ar_hs;
    rdy0 = ready_seen;
    ARREADY = 1'b1;
    issue(1'b0, 32'h0000_0040, '0, '0, 1'b1, 32'h1000_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6.ARVALID", ARVALID, 1);
      check("t6.ARADDR",  ARADDR,  32'h40 + 32'(4 * i));
      tick();
      RVALID = 1'b1; RDATA = 32'h1000_0000 + 32'(i); RRESP = 2'b00;
      tick();
      RVALID = 1'b0;
      pop_check("t6");
      if (i < 3) issue(1'b0, 32'h40 + 32'(4 * (i + 1)), '0, '0, 1'b1,
                       32'h1000_0000 + 32'(i + 1), 1'b0);
      else       DM_enable = 1'b0;
      tick();
      check("t6.idle_ready",   ready,   0);
      check("t6.idle_ARVALID", ARVALID, 0);
    end
    tick();
    check("t6.ar_handshakes", ar_hs - ar0, 4);
    check("t6.ready_pulses",  ready_seen - rdy0, 4);
    check("t6.rd_cnt", bus_rd_cnt, 4);
    check("t6.wr_cnt", bus_wr_cnt, 0);
    check("end.sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_axi_master.md
# dm_axi_master

Data-side bus master sitting directly downstream of the L1 data cache controller. It turns the cache's single-word memory requests (DM_enable / DM_write / DM_address plus write data) into single-beat AXI4-Lite transactions. It returns the result on the cache's `ready` / `DataIn` handshake. One transaction is outstanding at a time: refill words and write-through stores are serialized.

## Interface
- `ADDR_W`, 32, address width of DM_address and AXI addresses
- `DATA_W`, 32, data width; fixed to 32 in this design (WSTRB is 4 bits)
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0)
- `DM_enable`  input  1  request valid from cache controller; held until `ready`
- `DM_write`  input  1  1 = write, 0 = read; sampled with DM_enable
- `DM_address`  input  ADDR_W  byte address; sampled with DM_enable
- `DM_wdata`  input  DATA_W  store data; sampled with DM_enable when DM_write=1
- `DM_wstrb`  input  4  byte enables for writes; sampled with DM_enable
- `ready`  output  1  one-cycle completion pulse to the cache
- `DataIn`  output  DATA_W  read data; valid while `ready`=1, held until the next read completes
- `resp_err`  output  1  valid with `ready`; 1 if RRESP/BRESP != 2'b00
- `ARADDR`/`ARVALID`/`ARREADY`  out/out/in  ADDR_W/1/1  read address channel
- `RDATA`/`RRESP`/`RVALID`/`RREADY`  in/in/in/out  DATA_W/2/1/1  read data channel
- `AWADDR`/`AWVALID`/`AWREADY`  out/out/in  ADDR_W/1/1  write address channel
- `WDATA`/`WSTRB`/`WVALID`/`WREADY`  out/out/out/in  DATA_W/4/1/1  write data channel
- `BRESP`/`BVALID`/`BREADY`  in/in/out  2/1/1  write response channel
- `bus_rd_cnt`, `bus_wr_cnt`  output  64  completed read / write transactions (performance counters)

## Operation
- States: IDLE, AR, R, WR (AW+W), B, DONE.
- IDLE: if DM_enable=1, register the address word-aligned ({DM_address[31:2],2'b00}), plus DM_write, DM_wdata and DM_wstrb. Go to AR if read, WR if write. Otherwise stay.
- AR: ARVALID=1, ARADDR=registered address. On ARVALID&ARREADY go to R.
- R: RREADY=1. On RVALID go to DONE. DataIn <= RDATA; err <= (RRESP!=0).
- WR: AWVALID and WVALID are asserted together on entry and tracked by aw_done and w_done flags. Each valid drops the cycle after its own handshake. When both are done (including the same cycle), go to B.
- B: BREADY=1. On BVALID go to DONE; err <= (BRESP!=0).
- DONE: ready=1 and resp_err=err for exactly one cycle. Increment bus_rd_cnt or bus_wr_cnt by 1, wrapping at 2^64. Return to IDLE.
- DM_enable still high in the IDLE cycle after DONE is a new request. The controller changes address/enable in the `ready` cycle.
- Request inputs are ignored outside IDLE. Registered copies drive AXI, so mid-transaction input changes have no effect.
- Valids, once raised, stay high until their handshake; address and data stay stable while valid.
- An error response still completes normally. DataIn takes RDATA even on error. No retry.

## Timing
- Reset (rst=0), asynchronous: state=IDLE and every output = 0. This covers ready, DataIn, resp_err, all VALID/READY, ARADDR, AWADDR, WDATA, WSTRB and both counters.
- Reset mid-transaction drops all valids immediately. No completion pulse is generated; the counters clear.
- Request sampled at cycle N → ARVALID or AWVALID/WVALID first high at N+1.
- Minimum read latency, with ARREADY=1 and RVALID responding the cycle after the AR handshake:
  - AR handshake at N+1
  - R handshake at N+2
  - ready=1 at N+3
- Minimum write latency, with AWREADY=WREADY=1 and BVALID the next cycle:
  - AW/W handshake at N+1
  - B handshake at N+2
  - ready=1 at N+3
- Back-to-back requests: next request sampled at N+4 at the earliest. A 4-word refill takes at least 16 cycles.
- All outputs are registered; no combinational path from AXI inputs to outputs.

## Test plan
- Read, zero-wait slave: DM_enable=1, DM_write=0, DM_address=0x0000_1234 at N. Expect:
  - ARADDR=0x0000_1234 and ARVALID at N+1
  - RDATA=0xDEADBEEF → ready=1, DataIn=0xDEADBEEF, resp_err=0 at N+3
  - bus_rd_cnt=1
- Write with skewed channels: DM_address=0x0000_2008, DM_wdata=0x1122_3344, DM_wstrb=4'b0011. Slave gives AWREADY at N+1 and WREADY at N+4. Expect:
  - AWVALID drops at N+2
  - WVALID held with data stable until N+4
  - BREADY from N+5
  - ready one cycle after BVALID
  - bus_wr_cnt=1
- Read with stalls: ARREADY low 3 cycles and RVALID delayed 5 cycles. Expect ARVALID/ARADDR stable throughout and ready exactly one cycle wide. Changing DM_address mid-transaction must not alter ARADDR.
- Error responses: RRESP=2'b10 on a read, then BRESP=2'b11 on a write. Expect resp_err=1 coincident with each ready pulse, and both counters to increment.
- Refill burst: 4 sequential reads to 0x40, 0x44, 0x48, 0x4C with DM_enable held high. Expect 4 ready pulses, no duplicate or missing AXI reads, and bus_rd_cnt=4.
- Reset mid-transaction: assert rst=0 while in R with RVALID pending. Expect all outputs 0 immediately (asynchronously), state IDLE after release, and no ready pulse.
